// File: rtl/sram_col_mux_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sram_col_mux_seq
//  Summary  : Sequenced SRAM column multiplexer controller. Runs precharge,
//             isolation and write-drive/sense phases for one column per access.
//  Revision : 1.0  initial release
// ============================================================================
module sram_col_mux_seq #(
    parameter int WORD_W     = 8,
    parameter int MUX_RATIO  = 4,
    parameter int COL_W      = $clog2(MUX_RATIO),
    parameter int PRE_CYCLES = 1,
    parameter int ACC_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [COL_W-1:0]            req_col,
    input  logic [WORD_W-1:0]           req_wdata,
    output logic [MUX_RATIO-1:0]        col_sel,
    output logic [MUX_RATIO-1:0]        bl_oe,
    output logic [WORD_W*MUX_RATIO-1:0] bl_out,
    input  logic [WORD_W*MUX_RATIO-1:0] bl_in,
    output logic                        precharge_n,
    output logic                        sense_en,
    output logic                        write_en,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WORD_W-1:0]           rsp_rdata,
    output logic                        rsp_err
);

    localparam logic [7:0]     c_pre_last = 8'(PRE_CYCLES - 1);
    localparam logic [7:0]     c_acc_last = 8'(ACC_CYCLES - 1);
    localparam logic [COL_W:0] c_col_lim  = (COL_W + 1)'(MUX_RATIO);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ISO  = 3'd2,
        S_ACC  = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_live;
    logic                r_we;
    logic [COL_W-1:0]    r_col;
    logic [WORD_W-1:0]   r_wdata;
    logic                r_err;
    logic [WORD_W-1:0]   r_rdata;
    logic [7:0]          r_cnt;
    logic                w_accept;
    logic                w_col_bad;
    logic                w_acc;
    logic [WORD_W-1:0]   w_sensed;

    assign w_col_bad = ({1'b0, req_col} >= c_col_lim);
    assign req_ready = r_live && (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_acc     = (r_state == S_ACC);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_col_bad ? S_RSP : S_PRE;
            S_PRE:  if (r_cnt >= c_pre_last) w_next = S_ISO;
            S_ISO:  w_next = S_ACC;
            S_ACC:  if (r_cnt >= c_acc_last) w_next = S_RSP;
            S_RSP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sensed = '0;
        for (int c = 0; c < MUX_RATIO; c++) begin
            if (r_col == COL_W'(c)) w_sensed = bl_in[c*WORD_W +: WORD_W];
        end
    end

    // r_live holds req_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
            r_we    <= 1'b0;
            r_col   <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_accept) begin
                r_we    <= req_we;
                r_col   <= req_col;
                r_wdata <= req_wdata;
                r_err   <= w_col_bad;
                r_rdata <= '0;
            end
            if (w_acc && (w_next == S_RSP) && !r_we) begin
                r_rdata <= w_sensed;
            end
        end
    end

    for (genvar c = 0; c < MUX_RATIO; c++) begin : g_col
        assign col_sel[c] = w_acc && (r_col == COL_W'(c));
        assign bl_oe[c]   = col_sel[c] && r_we;
        assign bl_out[c*WORD_W +: WORD_W] = bl_oe[c] ? r_wdata : '0;
    end

    assign precharge_n = (r_state != S_PRE);
    assign write_en    = w_acc && r_we;
    assign sense_en    = w_acc && !r_we;
    assign rsp_valid   = (r_state == S_RSP);
    assign rsp_err     = rsp_valid && r_err;
    assign rsp_rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_col_mux_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_col_mux_seq
//  Summary  : Randomized self-checking bench for sram_col_mux_seq against a
//             phase-timeline reference model; second instance with MUX_RATIO=3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_col_mux_seq;

    localparam int W   = 8;
    localparam int MR  = 4;
    localparam int CW  = 2;
    localparam int PRE = 1;
    localparam int ACC = 2;
    localparam int LAT = PRE + 1 + ACC + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [CW-1:0]   req_col = '0;
    logic [W-1:0]    req_wdata = '0;
    logic [W*MR-1:0] bl_in = '0;
    logic            req_ready, precharge_n, sense_en, write_en, rsp_valid, rsp_err;
    logic [MR-1:0]   col_sel, bl_oe;
    logic [W*MR-1:0] bl_out;
    logic [W-1:0]    rsp_rdata;

    logic            req_valid3 = 0, req_we3 = 0, rsp_ready3 = 0;
    logic [1:0]      req_col3 = '0;
    logic [W-1:0]    req_wdata3 = '0;
    logic [W*3-1:0]  bl_in3 = '0;
    logic            req_ready3, precharge_n3, sense_en3, write_en3, rsp_valid3, rsp_err3;
    logic [2:0]      col_sel3, bl_oe3;
    logic [W*3-1:0]  bl_out3;
    logic [W-1:0]    rsp_rdata3;

    int errors = 0;
    int checks = 0;

    sram_col_mux_seq dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_col(req_col), .req_wdata(req_wdata), .col_sel(col_sel),
        .bl_oe(bl_oe), .bl_out(bl_out), .bl_in(bl_in), .precharge_n(precharge_n),
        .sense_en(sense_en), .write_en(write_en), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    sram_col_mux_seq #(.MUX_RATIO(3), .COL_W(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_we(req_we3), .req_col(req_col3), .req_wdata(req_wdata3), .col_sel(col_sel3),
        .bl_oe(bl_oe3), .bl_out(bl_out3), .bl_in(bl_in3), .precharge_n(precharge_n3),
        .sense_en(sense_en3), .write_en(write_en3), .rsp_valid(rsp_valid3),
        .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {one-hot-or-zero, oe subset of sel, no precharge overlap, no we/se overlap}
    function automatic logic [3:0] rules(input logic [MR-1:0] sel, input logic [MR-1:0] oe,
                                         input logic pn, input logic se, input logic we);
        rules[3] = $onehot0(sel);
        rules[2] = ((oe & ~sel) == '0);
        rules[1] = pn || ((sel == '0) && !se && !we);
        rules[0] = !(se && we);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        check_eq("invariants", rules(col_sel, bl_oe, precharge_n, sense_en, write_en), 4'hF);
        check_eq("invariants3", rules({1'b0, col_sel3}, {1'b0, bl_oe3}, precharge_n3,
                                      sense_en3, write_en3), 4'hF);
    endtask

    task automatic run_access(input logic we, input logic [CW-1:0] col,
                              input logic [W-1:0] wd, input int hold);
        logic [W-1:0]    exp_rd;
        logic [W*MR-1:0] exp_bl;
        logic [MR-1:0]   exp_sel;
        logic            in_acc;
        exp_rd  = we ? '0 : bl_in[int'(col)*W +: W];
        exp_bl  = '0;
        exp_bl[int'(col)*W +: W] = wd;
        exp_sel = '0;
        exp_sel[col] = 1'b1;
        check_eq("req_ready_idle", req_ready, 1);
        req_valid = 1; req_we = we; req_col = col; req_wdata = wd;
        tick();
        req_valid = 0; req_we = 1'($urandom); req_col = CW'($urandom); req_wdata = W'($urandom);
        for (int k = 1; k < LAT; k++) begin
            in_acc = (k >= PRE + 2) && (k <= PRE + 1 + ACC);
            check_eq("req_ready_busy", req_ready, 0);
            check_eq("rsp_valid_early", rsp_valid, 0);
            check_eq("precharge_n", precharge_n, (k <= PRE) ? 1'b0 : 1'b1);
            check_eq("col_sel", col_sel, in_acc ? exp_sel : '0);
            check_eq("bl_oe", bl_oe, (in_acc && we) ? exp_sel : '0);
            check_eq("bl_out", bl_out, (in_acc && we) ? exp_bl : '0);
            check_eq("write_en", write_en, in_acc && we);
            check_eq("sense_en", sense_en, in_acc && !we);
            rsp_ready = 1'($urandom);
            tick();
        end
        rsp_ready = 0;
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        check_eq("rsp_err", rsp_err, 0);
        check_eq("col_sel_rsp", col_sel, 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check_eq("rsp_valid_hold", rsp_valid, 1);
            check_eq("rsp_rdata_hold", rsp_rdata, exp_rd);
            check_eq("rsp_err_hold", rsp_err, 0);
            check_eq("req_ready_hold", req_ready, 0);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check_eq("rsp_valid_done", rsp_valid, 0);
        check_eq("req_ready_done", req_ready, 1);
    endtask

    initial begin
        // Reset state and release
        tick();
        tick();
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_precharge_n", precharge_n, 1);
        check_eq("rst_enables", {col_sel, bl_oe, sense_en, write_en, rsp_err}, 0);
        check_eq("rst_bl_out", bl_out, 0);
        check_eq("rst_rdata", rsp_rdata, 0);
        @(negedge clk);
        reset_n = 1;
        #1;
        check_eq("rel_req_ready_pre", req_ready, 0);
        tick();
        check_eq("rel_req_ready", req_ready, 1);
        check_eq("rel_precharge_n", precharge_n, 1);
        check_eq("rel_enables", {col_sel, bl_oe, sense_en, write_en}, 0);

        // Out-of-range column on MUX_RATIO=3 instance
        check_eq("m3_req_ready", req_ready3, 1);
        req_valid3 = 1; req_we3 = 0; req_col3 = 2'd3;
        tick();
        req_valid3 = 0;
        check_eq("m3_err_valid", rsp_valid3, 1);
        check_eq("m3_err_flag", rsp_err3, 1);
        check_eq("m3_err_rdata", rsp_rdata3, 0);
        check_eq("m3_err_array", {col_sel3, precharge_n3, sense_en3}, 3'b000_1_0);
        rsp_ready3 = 1;
        tick();
        rsp_ready3 = 0;
        check_eq("m3_err_done", {rsp_valid3, rsp_err3, req_ready3}, 3'b001);

        // In-range read on MUX_RATIO=3 instance
        bl_in3 = 24'hC3_11_22;
        req_valid3 = 1; req_col3 = 2'd2;
        tick();
        req_valid3 = 0;
        repeat (LAT - 1) tick();
        check_eq("m3_rd_valid", rsp_valid3, 1);
        check_eq("m3_rd_err", rsp_err3, 0);
        check_eq("m3_rd_data", rsp_rdata3, 8'hC3);
        rsp_ready3 = 1;
        tick();
        rsp_ready3 = 0;

        // Directed write, directed read, held response
        bl_in = 32'($urandom);
        run_access(1'b1, 2'd2, 8'hA5, 0);
        bl_in = {8'h3C, 8'hFF, 8'hFF, 8'hFF};
        run_access(1'b0, 2'd3, 8'h00, 0);
        bl_in = 32'($urandom);
        run_access(1'b0, 2'd1, 8'h00, 4);

        // Random back-to-back traffic
        for (int n = 0; n < 24; n++) begin
            bl_in = 32'($urandom);
            run_access(1'($urandom), CW'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset during ACC of a write
        req_valid = 1; req_we = 1; req_col = 2'd0; req_wdata = 8'h5A;
        tick();
        req_valid = 0;
        repeat (PRE + 1) tick();
        check_eq("mid_write_en", write_en, 1);
        #2;
        reset_n = 0;
        #1;
        check_eq("abort_col_sel", col_sel, 0);
        check_eq("abort_bl_oe", bl_oe, 0);
        check_eq("abort_write_en", write_en, 0);
        check_eq("abort_bl_out", bl_out, 0);
        check_eq("abort_pn_ready", {precharge_n, req_ready}, 2'b10);
        tick();
        tick();
        #2;
        reset_n = 1;
        tick();
        check_eq("abort_req_ready", req_ready, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_eq("abort_no_rsp", rsp_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
